// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
// Valid/ready on both sides; result registered and held in DONE.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SAFE_C = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N      = (WIDTH / SAFE_C < 1) ? 1 : WIDTH / SAFE_C;
  localparam int KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % SAFE_C) != 0) begin : g_bad_params
    $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [WIDTH-1:0] s_q;
  logic             carry_q, sub_q, cout_q, ovf_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   csum;
  int               base;
  logic             last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign last      = (k_q == KLAST);

  // One chunk of the ripple: select chunk k, add with carry, merge into sum
  always_comb begin
    base  = int'(k_q) * CHUNK;
    ca    = a_q[base +: CHUNK];
    cb    = b_q[base +: CHUNK];
    csum  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
    sum_d = sum_q;
    sum_d[base +: CHUNK] = csum[CHUNK-1:0];
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture, per-chunk update and result registration
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            sub_q   <= sub;
            k_q     <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= csum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last) begin
            s_q    <= sum_d;
            cout_q <= csum[CHUNK] ^ sub_q;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: 32/4 instance plus an 8/8 instance.
// Expected values are hand-computed constants.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] a, b, s;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf;

  logic        in_valid8, in_ready8;
  logic [7:0]  a8, b8, s8;
  logic        out_valid8, cout8, ovf8;

  int vecs = 0;
  int errs = 0;
  int lat;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .s(s8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, output int l);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = ~tb; cin = ~tc; sub = ~ts;
    l = 0;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] es,
                           input logic ec, input logic eo, input int l);
    chk({tag, ".lat"}, 32'(l), 32'd8);
    chk({tag, ".s"}, s, es);
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ovld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".irdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.s", s, 32'h0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);

    run_op(32'h0000000F, 32'h00000001, 1'b0, 1'b0, lat);
    check_res("f_plus_1", 32'h00000010, 1'b0, 1'b0, lat);
    release_out("f_plus_1");

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    check_res("ripple", 32'h00000000, 1'b1, 1'b0, lat);
    release_out("ripple");

    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat);
    check_res("ripple_cin", 32'h00000000, 1'b1, 1'b0, lat);
    release_out("ripple_cin");

    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    check_res("ovf_add", 32'h80000000, 1'b0, 1'b1, lat);
    release_out("ovf_add");

    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
    check_res("ovf_sub", 32'h7FFFFFFF, 1'b0, 1'b1, lat);
    release_out("ovf_sub");

    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, lat);
    check_res("borrow", 32'hFFFFFFFE, 1'b1, 1'b0, lat);
    release_out("borrow");

    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run.s_hold", s, 32'hFFFFFFFE);
      chk("run.in_ready", 32'(in_ready), 32'd0);
      chk("run.out_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.s", s, 32'h0);
    chk("abort.cout", 32'(cout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort.no_result", 32'(out_valid), 32'd0);
    end

    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    check_res("after_abort", 32'h23456789, 1'b0, 1'b0, lat);
    release_out("after_abort");

    run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, lat);
    check_res("sub_cin", 32'h00000001, 1'b0, 1'b0, lat);
    release_out("sub_cin");

    run_op(32'h40000000, 32'h40000000, 1'b0, 1'b0, lat);
    check_res("bp", 32'h80000000, 1'b0, 1'b1, lat);
    a = 32'h00000003; b = 32'h00000004; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.s", s, 32'h80000000);
      chk("bp.ovf", 32'(ovf), 32'd1);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.ovld_drop", 32'(out_valid), 32'd0);
    chk("bp.irdy_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_res("bp_queued", 32'h00000007, 1'b0, 1'b0, lat);
    release_out("bp_queued");

    a8 = 8'h0F; b8 = 8'h01; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    chk("w8.lat", 32'(lat), 32'd1);
    chk("w8.s", 32'(s8), 32'h10);
    chk("w8.cout", 32'(cout8), 32'd0);
    chk("w8.ovf", 32'(ovf8), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("w8.ovld_drop", 32'(out_valid8), 32'd0);
    chk("w8.irdy_back", 32'(in_ready8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
